data_memory_unit: RTL

- Data-memory stage directly downstream of the ALU.
- Consumes ALUResult as the byte address and the rt register value as store data.
- Performs byte, halfword and word loads and stores against an internal word-organised RAM with a configurable number of wait states.
- Holds the processor via Stall until each access completes, and flags misaligned accesses.

---
 rtl/data_memory_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/data_memory_unit.sv
// Data-memory stage: byte/halfword/word loads and stores against an internal
// word-organised RAM with a configurable number of wait states.
//
// Ports:
//   CLK, RST      clock (rising edge), asynchronous active-low reset
//   MemRead       load request
//   MemWrite      store request (wins when both requests are high)
//   MemSize       00 byte, 01 halfword, 10 word, 11 illegal
//   MemSigned     loads only: 1 sign-extends, 0 zero-extends
//   ALUResult     byte address; bits above the RAM index are ignored
//   WriteData     store data, right-justified
//   ReadData      registered load result, held until the next completed load
//   Stall         combinational: high while an aligned access is in flight
//   MisalignErr   registered one-cycle pulse for a misaligned/illegal request
module data_memory_unit #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignErr
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               stall_c;
    logic               commit_c;

    logic [31:0]        ram [DEPTH];

    logic [IDX_W-1:0]   idx;
    logic [1:0]         lane;
    logic               req;
    logic               is_store;
    logic               misaligned;
    logic               good_req;
    logic               bad_req;

    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        load_val;
    logic [31:0]        wr_word;

    // Address bits above the RAM index only wrap the address space.
    logic unused_addr;
    assign unused_addr = ^ALUResult[31:IDX_W+2];

    assign idx      = ALUResult[IDX_W+1:2];
    assign lane     = ALUResult[1:0];
    assign req      = MemRead | MemWrite;
    assign is_store = MemWrite;

    // Alignment check per access size; size 11 is always rejected.
    always_comb begin
        misaligned = 1'b0;
        case (MemSize)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    assign good_req = req & ~misaligned;
    assign bad_req  = req &  misaligned;

    // Lane extraction for loads (little-endian, lane 0 = bits [7:0]).
    assign rd_word = ram[idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_val = rd_word;
        case (MemSize)
            2'b00:   load_val = {{24{MemSigned & rd_byte[7]}}, rd_byte};
            2'b01:   load_val = {{16{MemSigned & rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // Byte-lane merge for stores; unselected lanes keep their old contents.
    always_comb begin
        wr_word = rd_word;
        case (MemSize)
            2'b00:   wr_word[{lane, 3'b000} +: 8]     = WriteData[7:0];
            2'b01:   wr_word[{lane[1], 4'b0000} +: 16] = WriteData[15:0];
            default: wr_word = WriteData;
        endcase
    end

    // Next-state and control: the access commits on the edge leaving the last stall cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_c   = 1'b0;
        commit_c  = 1'b0;
        case (state)
            IDLE: begin
                if (good_req) begin
                    stall_c = 1'b1;
                    if (WAIT_STATES == 0) begin
                        commit_c  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = CNT_W'(WAIT_STATES);
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    commit_c  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stall is forced low while reset is held so the pipeline is released immediately.
    assign Stall = stall_c & RST;

    // State, counter and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            cnt         <= '0;
            ReadData    <= '0;
            MisalignErr <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            MisalignErr <= (state == IDLE) & bad_req;
            if (commit_c && !is_store) begin
                ReadData <= load_val;
            end
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge CLK) begin
        if (commit_c && is_store) begin
            ram[idx] <= wr_word;
        end
    end

endmodule
